// File: rtl/elevator_door_ctrl.sv
// Cabin door sequencer: opens on car arrival, dwells, closes, and reopens on hold.
// Reports door_closed as the move-permit and drives chime, nudge and overload alarm.
module elevator_door_ctrl #(
    parameter int unsigned MOVE_CYCLES  = 4,
    parameter int unsigned DWELL_CYCLES = 10,
    parameter int unsigned MAX_REOPEN   = 3,
    parameter int unsigned CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       complete,
    input  logic [2:0] out_floor,
    input  logic       over_weight,
    input  logic       obstruct,
    input  logic       open_btn,
    input  logic       close_btn,
    output logic       open_cmd,
    output logic       close_cmd,
    output logic       door_closed,
    output logic [1:0] door_state,
    output logic [2:0] arrive_floor,
    output logic       chime,
    output logic       nudge,
    output logic       alarm
);

    typedef enum logic [1:0] {
        ST_CLOSED  = 2'd0,
        ST_OPENING = 2'd1,
        ST_OPEN    = 2'd2,
        ST_CLOSING = 2'd3
    } door_state_e;

    localparam int unsigned RO_W = (MAX_REOPEN < 1) ? 1 : $clog2(MAX_REOPEN + 1);

    localparam logic [CNT_W-1:0] MOVE_LOAD  = CNT_W'(MOVE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [RO_W-1:0]  RO_MAX     = RO_W'(MAX_REOPEN);
    localparam logic [RO_W-1:0]  RO_ONE     = RO_W'(1);

    door_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RO_W-1:0]  reopen_q, reopen_d;
    logic             complete_q;
    logic             arrival;
    logic             hold;
    logic             capture_floor;
    logic             cnt_zero;

    assign arrival  = complete & ~complete_q;
    assign hold     = obstruct | open_btn | over_weight;
    assign cnt_zero = (cnt_q == '0);

    // NOTE: every signal driven here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        reopen_d      = reopen_q;
        capture_floor = 1'b0;

        case (state_q)
            ST_CLOSED: begin
                if (arrival) begin
                    state_d       = ST_OPENING;
                    cnt_d         = MOVE_LOAD;
                    capture_floor = 1'b1;
                end else if (open_btn && complete) begin
                    state_d = ST_OPENING;
                    cnt_d   = MOVE_LOAD;
                end
            end

            ST_OPENING: begin
                if (cnt_zero) begin
                    state_d = ST_OPEN;
                    cnt_d   = DWELL_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_OPEN: begin
                // A hold always wins over the close button.
                if (hold) begin
                    cnt_d = DWELL_LOAD;
                end else if (close_btn || cnt_zero) begin
                    state_d = ST_CLOSING;
                    cnt_d   = MOVE_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            ST_CLOSING: begin
                if (hold) begin
                    state_d = ST_OPENING;
                    cnt_d   = MOVE_LOAD;
                    if (reopen_q != RO_MAX) begin
                        reopen_d = reopen_q + RO_ONE;
                    end
                end else if (cnt_zero) begin
                    state_d  = ST_CLOSED;
                    reopen_d = '0;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            default: begin
                state_d  = ST_CLOSED;
                cnt_d    = '0;
                reopen_d = '0;
            end
        endcase
    end

    // complete_q resets high so a car already parked at reset never looks like an arrival.
    // NOTE: state is updated with non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_CLOSED;
            cnt_q        <= '0;
            reopen_q     <= '0;
            complete_q   <= 1'b1;
            arrive_floor <= '0;
            chime        <= 1'b0;
            alarm        <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            reopen_q   <= reopen_d;
            complete_q <= complete;
            chime      <= capture_floor;
            alarm      <= over_weight & (state_q != ST_CLOSED);
            if (capture_floor) begin
                arrive_floor <= out_floor;
            end
        end
    end

    assign door_state  = state_q;
    assign open_cmd    = (state_q == ST_OPENING);
    assign close_cmd   = (state_q == ST_CLOSING);
    assign door_closed = (state_q == ST_CLOSED);
    assign nudge       = (reopen_q == RO_MAX);

endmodule

// File: doc/elevator_door_ctrl.md
# elevator_door_ctrl

Cabin door controller sitting directly downstream of the elevator car controller. It consumes the car's `complete`, `out_floor` and `over_weight` status and sequences the door through open, dwell and close. It handles obstruction, cabin open/close buttons and overload hold. It reports `door_closed` back as the move-permit and produces an arrival chime and a nudge buzzer.

## Interface
- `MOVE_CYCLES`, 4: door travel time in cycles, for both opening and closing; must be ≥1.
- `DWELL_CYCLES`, 10: door-open dwell time in cycles; must be ≥1.
- `MAX_REOPEN`, 3: count of reopens during a closing that asserts `nudge`.
- `CNT_W`, 8: width of the timer counter; must hold max(MOVE_CYCLES, DWELL_CYCLES)−1.
- `clk` in 1: single clock; everything updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `complete` in 1: car at its target floor and stopped; a 0→1 edge is an arrival.
- `out_floor` in 3: car's current floor.
- `over_weight` in 1: cabin load exceeds the limit.
- `obstruct` in 1: door-edge light curtain is blocked.
- `open_btn` in 1: cabin door-open button, level-sensitive.
- `close_btn` in 1: cabin door-close button, level-sensitive.
- `open_cmd` out 1: door motor open drive.
- `close_cmd` out 1: door motor close drive.
- `door_closed` out 1: door fully closed; the car may move only while this is 1.
- `door_state` out 2: CLOSED=0, OPENING=1, OPEN=2, CLOSING=3.
- `arrive_floor` out 3: floor captured at the last arrival.
- `chime` out 1: one-cycle pulse on arrival.
- `nudge` out 1: reopen limit reached.
- `alarm` out 1: overload buzzer.

## Operation
- `complete_q` is the registered copy of `complete` and resets to 1, so no arrival is seen out of reset.
- `arrival = complete & ~complete_q`.
- `hold = obstruct | open_btn | over_weight`.
- `cnt` is a down-counter of CNT_W bits. State transitions happen when `cnt == 0` unless stated otherwise.

State machine:
- **CLOSED**
  - `arrival` → OPENING, `cnt = MOVE_CYCLES−1`, `arrive_floor <= out_floor`, `chime` = 1 for the next cycle only.
  - Else if `open_btn & complete` → OPENING, same reload, no chime, `arrive_floor` unchanged.
  - `obstruct` alone does nothing in this state.
  - Entry to CLOSED clears the reopen count.
- **OPENING**
  - `open_cmd = 1`; `cnt` decrements.
  - At 0 → OPEN, `cnt = DWELL_CYCLES−1`.
  - Inputs are ignored during opening.
- **OPEN**
  - If `hold`: `cnt` reloads to DWELL_CYCLES−1.
  - Else if `close_btn`: → CLOSING immediately, `cnt = MOVE_CYCLES−1`.
  - Else `cnt` decrements; at 0 → CLOSING with the same reload.
- **CLOSING**
  - `close_cmd = 1`.
  - If `hold`: → OPENING, `cnt = MOVE_CYCLES−1`, reopen count increments, saturating at MAX_REOPEN.
  - Else `cnt` decrements; at 0 → CLOSED.
- `hold` is checked before `close_btn`, so `close_btn` never overrides a hold.
- Outputs:
  - `door_closed = (state == CLOSED)`.
  - `open_cmd` and `close_cmd` are never 1 together.
  - `nudge = (reopen count == MAX_REOPEN)`; it stays high until CLOSED is entered.
  - `alarm = over_weight & (state != CLOSED)`, registered.
- Reset at any point, including mid-travel:
  - State → CLOSED, `cnt = 0`, reopen count = 0.
  - `open_cmd = close_cmd = 0`, `door_closed = 1`, `door_state = 0`, `arrive_floor = 0`, `chime = 0`, `nudge = 0`, `alarm = 0`, `complete_q = 1`.

## Timing
- All outputs are registered or decoded from state, so there is no combinational input→output path.
- Arrival sampled at edge N:
  - `door_state` = OPENING and `chime` = 1 from N+1.
  - `chime` = 0 from N+2.
  - OPEN from N+1+MOVE_CYCLES.
  - CLOSING from N+1+MOVE_CYCLES+DWELL_CYCLES.
  - CLOSED from N+1+2·MOVE_CYCLES+DWELL_CYCLES.
- `open_cmd` is high for exactly MOVE_CYCLES cycles; `close_cmd` likewise on an undisturbed close.
- The `hold` effect appears one cycle after it is sampled.
- Arrival edges arriving while not CLOSED are ignored. `complete_q` still tracks, so there is no retrigger later.
- `complete` falling while the door is open has no effect; the car controller must honour `door_closed`.

## Test plan
- **Basic cycle:** reset, then `complete` 1→0→1 with `out_floor=5`, sampled at edge N → `chime` pulse at N+1 only, `arrive_floor=5`, `open_cmd` high N+1..N+4, OPEN N+5..N+14, `close_cmd` high N+15..N+18, `door_closed=1` at N+19.
- **Dwell extension:** `obstruct` high for 3 cycles starting at OPEN cycle 6 → CLOSING is delayed so it begins 10 cycles after `obstruct` falls.
- **Reopen and nudge:** `obstruct` pulsed in three successive CLOSING phases → 3 returns to OPENING, `nudge=1` after the third, cleared on reaching CLOSED.
- **Overload:** `over_weight=1` held during OPEN → door stays OPEN and `alarm=1`; drop `over_weight` → `alarm` = 0 next cycle and CLOSING begins 10 cycles later.
- **Close button:** `close_btn` during OPEN cycle 2 with no hold → CLOSING next cycle. With `open_btn` also high → stays OPEN.
- **Reset mid-operation:** `rst` during OPENING → `door_closed=1`, all commands 0, next cycle. `complete` held at 1 through reset → no arrival and no chime.
